// File: rtl/chunked_addsub_if.sv
// chunked_addsub_if: operand/result handshake bundle for chunked_addsub_unit
interface chunked_addsub_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, busy
  );
  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/chunked_addsub_unit.sv
// chunked_addsub_unit: multi-cycle add/subtract, one CHUNK-bit look-ahead slice per clock
module chunked_addsub_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic             clk,
  input logic             rst,
  chunked_addsub_if.slave io
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, bx_r, res_r;
  logic [KW-1:0]    k;
  logic             c, cout_r, ovf_r;
  logic [CHUNK-1:0] sa, sb, g, p, s;
  logic [CHUNK:0]   cc;
  logic             t, acc, last, accept;
  assign accept       = state == IDLE && io.in_valid;
  assign last         = k == KW'(N - 1);
  assign sa           = CHUNK'(a_r >> (k * CHUNK));
  assign sb           = CHUNK'(bx_r >> (k * CHUNK));
  assign io.in_ready  = state == IDLE;
  assign io.out_valid = state == DONE;
  assign io.busy      = state != IDLE;
  assign io.result    = res_r;
  assign io.carry_out = cout_r;
  assign io.overflow  = ovf_r;
  // each slice carry is a flat sum of generate/propagate products, no ripple chain
  always_comb begin
    g = sa & sb;
    p = sa ^ sb;
    cc = '0;
    cc[0] = c;
    t = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      acc = c;
      for (int j = 0; j <= i; j++) acc = acc & p[j];
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        acc = acc | t;
      end
      cc[i+1] = acc;
    end
    s = p ^ cc[CHUNK-1:0];
  end
  always_comb
    state_n = state == IDLE ? (io.in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              (io.out_ready ? IDLE : DONE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      bx_r   <= '0;
      res_r  <= '0;
      k      <= '0;
      c      <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_r  <= io.a;
        bx_r <= io.sub ? ~io.b : io.b;
        c    <= io.sub ^ io.cin;
        k    <= '0;
      end else if (state == RUN) begin
        res_r[k*CHUNK +: CHUNK] <= s;
        c <= cc[CHUNK];
        k <= k + KW'(!last);
        if (last) begin
          cout_r <= cc[CHUNK];
          ovf_r  <= cc[CHUNK] ^ cc[CHUNK-1];
        end
      end
    end
endmodule

// File: tb/tb_chunked_addsub_unit.sv
// tb_chunked_addsub_unit: scoreboard bench for chunked_addsub_unit
module tb_chunked_addsub_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_rdy = 1'b0;
  logic fixed_rdy = 1'b1;
  int total = 0;
  int bad = 0;
  int sent = 0;
  int got = 0;
  logic [33:0] exp_q[$];
  chunked_addsub_if #(.WIDTH(32)) ifc ();
  chunked_addsub_unit #(.WIDTH(32), .CHUNK(8)) dut (.clk(clk), .rst(rst), .io(ifc));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 ifc.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [33:0] model(input logic [31:0] av, bv, input logic sv, cv);
    logic [31:0] bx;
    logic [32:0] sm;
    bx = sv ? ~bv : bv;
    sm = {1'b0, av} + {1'b0, bx} + 33'(sv ? !cv : cv);
    return {(av[31] == bx[31]) && (sm[31] != av[31]), sm[32], sm[31:0]};
  endfunction
  always @(negedge clk)
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        got++;
        chk("result", ifc.result, e[31:0]);
        chk("carry_out", ifc.carry_out, e[32]);
        chk("overflow", ifc.overflow, e[33]);
      end
    end
  task automatic send(input logic [31:0] av, bv, input logic sv, cv, input logic [33:0] e, input bit push);
    bit ok = 0;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b1;
    ifc.a = av;
    ifc.b = bv;
    ifc.sub = sv;
    ifc.cin = cv;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        ok = 1;
        if (push) begin
          exp_q.push_back(e);
          sent++;
        end
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.a = $urandom;
    ifc.b = $urandom;
    ifc.sub = 1'($urandom);
    ifc.cin = 1'($urandom);
  endtask
  task automatic drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask
  initial begin
    ifc.in_valid = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    ifc.sub = 1'b0;
    ifc.cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_outs", {ifc.result, ifc.carry_out, ifc.overflow}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}, 1);
    repeat (4) begin
      @(negedge clk);
      chk("latency_low", ifc.out_valid, 0);
    end
    @(negedge clk);
    chk("latency_high", ifc.out_valid, 1);
    drain(50);
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, {1'b1, 1'b1, 32'h7FFF_FFFF}, 1);
    send(32'hFFFF_FFFC, 32'h0000_0005, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0001}, 1);
    send(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, 1);
    drain(50);
    fixed_rdy = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, {1'b0, 1'b0, 32'h2345_6789}, 1);
    for (int i = 0; i < 20 && !ifc.out_valid; i++) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", ifc.out_valid, 1);
      chk("bp_in_ready", ifc.in_ready, 0);
      chk("bp_result", ifc.result, 32'h2345_6789);
    end
    fixed_rdy = 1'b1;
    for (int i = 0; i < 20 && ifc.out_valid; i++) @(negedge clk);
    chk("bp_release_in_ready", ifc.in_ready, 1);
    drain(50);
    send(32'hFFFF_FFF6, 32'hFFFF_FFEC, 1'b0, 1'b0, '0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_in_ready", ifc.in_ready, 1);
    chk("midrst_busy", ifc.busy, 0);
    chk("midrst_out_valid", ifc.out_valid, 0);
    chk("midrst_outs", {ifc.result, ifc.carry_out, ifc.overflow}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_valid", ifc.out_valid, 0);
    end
    send(32'h0000_000A, 32'h0000_000A, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_0014}, 1);
    drain(50);
    rand_rdy = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] av, bv;
      logic sv, cv;
      av = $urandom;
      bv = $urandom;
      sv = 1'($urandom);
      cv = 1'($urandom);
      if (n % 8 == 0) av = 32'h8000_0000 ^ 32'(n);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(av, bv, sv, cv, model(av, bv, sv, cv), 1);
    end
    drain(2000);
    chk("op_count", got, sent);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
